// File: rtl/morse_digit_decoder.sv
// Purpose: time presses of a raw Morse key, collect dot/dash symbols, decode 5-symbol digits.
// Latency: flag/err rise GAP_CYCLES+1 clk after the final debounced release of a character.
// Backpressure: none; flag and err are single-cycle pulses, keyboard_val holds the last digit.
module morse_digit_decoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DASH_CYCLES     = 20_000_000,
  parameter int GAP_CYCLES      = 50_000_000,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  output logic [3:0] keyboard_val,
  output logic       flag,
  output logic       err,
  output logic [2:0] sym_cnt,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LIM = CNT_W'(DASH_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    EMIT  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // Synchronizer and debouncer come out of reset in the "pressed" level, so a
  // key held through reset never produces a rising edge: the block has to see
  // the release before the next press can open a character.
  logic             key_s1;
  logic             key_s2;
  logic             k;
  logic             k_prev;
  logic [CNT_W-1:0] db_cnt;

  logic [CNT_W-1:0] dur;
  logic [CNT_W-1:0] gap;
  logic [4:0]       sym;
  logic             ovf;

  logic             k_rise;
  logic             k_fall;
  logic             dur_clr;
  logic             gap_clr;
  logic             push_sym;
  logic             emit_go;
  logic             char_clr;
  logic             dash_bit;

  logic [3:0]       digit;
  logic             pat_hit;
  logic             valid_char;

  assign k_rise   = k & ~k_prev;
  assign k_fall   = ~k & k_prev;
  assign dash_bit = (dur >= DASH_LIM);
  assign busy     = (state != IDLE);

  // Two-flop synchronizer for the asynchronous key input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

  // Debouncer: accept a new level only after it has differed for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k      <= 1'b1;
      db_cnt <= '0;
    end else if (key_s2 != k) begin
      if (db_cnt == DB_LAST) begin
        k      <= key_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Previous debounced level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_prev <= 1'b1;
    end else begin
      k_prev <= k;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and datapath control strobes.
  always_comb begin
    state_nxt = state;
    dur_clr   = 1'b0;
    gap_clr   = 1'b0;
    push_sym  = 1'b0;
    emit_go   = 1'b0;
    char_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (k_rise) begin
          state_nxt = PRESS;
          dur_clr   = 1'b1;
        end
      end
      PRESS: begin
        if (k_fall) begin
          state_nxt = GAP;
          push_sym  = 1'b1;
          gap_clr   = 1'b1;
        end
      end
      GAP: begin
        if (k_rise) begin
          state_nxt = PRESS;
          dur_clr   = 1'b1;
        end else if (gap == GAP_LAST) begin
          // gap reaches GAP_CYCLES on this edge; outputs are loaded as EMIT is entered.
          state_nxt = EMIT;
          emit_go   = 1'b1;
        end
      end
      EMIT: begin
        state_nxt = IDLE;
        char_clr  = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Press duration counter, saturating at the dash threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur <= '0;
    end else if (dur_clr) begin
      dur <= '0;
    end else if ((state == PRESS) && (dur != DASH_LIM)) begin
      dur <= dur + 1'b1;
    end
  end

  // Release gap counter; the FSM leaves GAP before it can wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap <= '0;
    end else if (gap_clr) begin
      gap <= '0;
    end else if (state == GAP) begin
      gap <= gap + 1'b1;
    end
  end

  // Symbol collection: first symbol ends up in the MSB; a sixth symbol marks overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym     <= '0;
      sym_cnt <= '0;
      ovf     <= 1'b0;
    end else if (char_clr) begin
      sym     <= '0;
      sym_cnt <= '0;
      ovf     <= 1'b0;
    end else if (push_sym) begin
      if (sym_cnt == 3'd5) begin
        ovf <= 1'b1;
      end else begin
        sym     <= {sym[3:0], dash_bit};
        sym_cnt <= sym_cnt + 3'd1;
      end
    end
  end

  // Digit lookup for a complete 5-symbol pattern.
  always_comb begin
    digit   = 4'd0;
    pat_hit = 1'b1;
    case (sym)
      5'b01111: digit = 4'd1;
      5'b00111: digit = 4'd2;
      5'b00011: digit = 4'd3;
      5'b00001: digit = 4'd4;
      5'b00000: digit = 4'd5;
      5'b10000: digit = 4'd6;
      5'b11000: digit = 4'd7;
      5'b11100: digit = 4'd8;
      5'b11110: digit = 4'd9;
      5'b11111: digit = 4'd0;
      default:  pat_hit = 1'b0;
    endcase
  end

  assign valid_char = (sym_cnt == 3'd5) && !ovf && pat_hit;

  // Output register: one pulse per closed character, keyboard_val only moves on a valid digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyboard_val <= 4'd0;
      flag         <= 1'b0;
      err          <= 1'b0;
    end else begin
      flag <= emit_go && valid_char;
      err  <= emit_go && !valid_char;
      if (emit_go && valid_char) begin
        keyboard_val <= digit;
      end
    end
  end

endmodule

// File: tb/tb_morse_digit_decoder.sv
// Bench for morse_digit_decoder: table of characters plus hand-written corner sequences.
// Expected pulses are queued when a character is keyed and checked when flag/err appear.
// Small timing parameters keep every scenario to a few hundred clocks.
module tb_morse_digit_decoder;

  localparam int DB   = 4;
  localparam int DASH = 20;
  localparam int GAP  = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b0;
  logic [3:0] keyboard_val;
  logic       flag;
  logic       err;
  logic [2:0] sym_cnt;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [3:0] val;
  } exp_t;

  typedef struct {
    int         n;
    logic [5:0] pat;
    bit         is_err;
    logic [3:0] val;
  } vec_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  vec_t       vecs[15];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] model_val = 4'd0;
  int         lat;

  morse_digit_decoder #(
    .DEBOUNCE_CYCLES(DB),
    .DASH_CYCLES    (DASH),
    .GAP_CYCLES     (GAP),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .keyboard_val(keyboard_val),
    .flag        (flag),
    .err         (err),
    .sym_cnt     (sym_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic vec_t mk(input int n, input logic [5:0] p, input bit e, input logic [3:0] v);
    vec_t r;
    r.n = n; r.pat = p; r.is_err = e; r.val = v;
    return r;
  endfunction

  // Key n symbols (symbol i is pat[n-1-i], 1 = dash), 10-clk gaps, returns right after last release.
  task automatic press_syms(input int n, input logic [5:0] pat);
    for (int i = 0; i < n; i++) begin
      key = 1'b1;
      idle(pat[n-1-i] ? 30 : 5);
      key = 1'b0;
      if (i != n - 1) idle(10);
    end
  endtask

  task automatic push_exp(input bit is_err, input logic [3:0] val);
    exp_t e;
    e.is_err = is_err;
    e.val    = is_err ? model_val : val;
    if (!is_err) model_val = val;
    sbq.push_back(e);
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (sbq.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: %0d expected pulse(s) never arrived, want 0 pending", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic send_char(input vec_t v);
    push_exp(v.is_err, v.val);
    press_syms(v.n, v.pat);
    idle(60);
    drain("char_pulse");
  endtask

  // Scoreboard monitor: every flag/err cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (flag || err)) begin
      chk("flag_err_exclusive", int'(flag && err), 0);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: flag=%0d err=%0d val=%0d, want no pulse (t=%0t)",
                 flag, err, keyboard_val, $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("pulse_err", int'(err), int'(mon_e.is_err));
        chk("pulse_flag", int'(flag), int'(!mon_e.is_err));
        chk("keyboard_val", int'(keyboard_val), int'(mon_e.val));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(5, 6'b001111, 1'b0, 4'd1);
    vecs[1]  = mk(3, 6'b000000, 1'b1, 4'd0);
    vecs[2]  = mk(6, 6'b000000, 1'b1, 4'd0);
    vecs[3]  = mk(5, 6'b000000, 1'b0, 4'd5);
    vecs[4]  = mk(5, 6'b011111, 1'b0, 4'd0);
    vecs[5]  = mk(5, 6'b000111, 1'b0, 4'd2);
    vecs[6]  = mk(5, 6'b000011, 1'b0, 4'd3);
    vecs[7]  = mk(5, 6'b000001, 1'b0, 4'd4);
    vecs[8]  = mk(5, 6'b010000, 1'b0, 4'd6);
    vecs[9]  = mk(5, 6'b011000, 1'b0, 4'd7);
    vecs[10] = mk(5, 6'b011100, 1'b0, 4'd8);
    vecs[11] = mk(5, 6'b011110, 1'b0, 4'd9);
    vecs[12] = mk(5, 6'b001010, 1'b1, 4'd0);
    vecs[13] = mk(1, 6'b000001, 1'b1, 4'd0);
    vecs[14] = mk(4, 6'b001111, 1'b1, 4'd0);

    // Reset state.
    idle(3);
    chk("rst_keyboard_val", int'(keyboard_val), 0);
    chk("rst_flag", int'(flag), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_sym_cnt", int'(sym_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    idle(20);
    chk("idle_busy", int'(busy), 0);

    // Table of characters: digits, short, long and unknown patterns.
    for (int i = 0; i < 15; i++) begin
      send_char(vecs[i]);
      chk("after_char_busy", int'(busy), 0);
      chk("after_char_sym_cnt", int'(sym_cnt), 0);
    end

    // Five dashes: latency from raw release is 2 sync + DB debounce + GAP+1.
    push_exp(1'b0, 4'd0);
    press_syms(5, 6'b011111);
    lat = 0;
    while (!flag && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("flag_latency", lat, DB + 2 + GAP + 1);
    @(negedge clk);
    chk("flag_width", int'(flag), 0);
    idle(10);
    drain("latency_pulse");

    // Bounce shorter than the debounce window never opens a character.
    for (int i = 0; i < 10; i++) begin
      key = ~key;
      idle(2);
      chk("bounce_sym_cnt", int'(sym_cnt), 0);
      chk("bounce_busy", int'(busy), 0);
    end
    key = 1'b0;
    idle(80);
    chk("bounce_end_busy", int'(busy), 0);

    // Reset while a fourth press is held after three symbols.
    press_syms(3, 6'b000111);
    idle(10);
    key = 1'b1;
    idle(15);
    chk("pre_rst_sym_cnt", int'(sym_cnt), 3);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_keyboard_val", int'(keyboard_val), 0);
    chk("mid_rst_flag", int'(flag), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_sym_cnt", int'(sym_cnt), 0);
    chk("mid_rst_busy", int'(busy), 0);
    model_val = 4'd0;
    idle(3);
    rst = 1'b0;
    // Key still held after reset: no press may be registered until it is released.
    idle(20);
    chk("held_after_rst_busy", int'(busy), 0);
    key = 1'b0;
    idle(80);
    chk("released_after_rst_busy", int'(busy), 0);
    send_char(mk(5, 6'b011000, 1'b0, 4'd7));
    chk("post_rst_char_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
